alu_ctrl_exec: RTL and testbench
================================

// Module: alu_ctrl_exec
// PURPOSE
//  Parametrised successor to the combinational ALU-control decoder: decodes ALUOp/funct and executes the op.
//  Single-cycle ops (add/sub/logic/slt) return a registered result; mult/div run iteratively into HI/LO.
//  Sits in the MIPS EX stage, between the main control unit and the EX/MEM boundary.
//  Uses a valid/ready handshake, so the pipeline stalls while a mult or div is in progress.
// PARAMETERS
//  WIDTH          32  operand/result width in bits; must be >= 4
//  ENABLE_MULDIV  1   1: mult/multu/div/divu/mfhi/mflo implemented; 0: those functs decode as illegal
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      synchronous reset, active-low
//  in_valid   in   1      request present
//  in_ready   out  1      block can accept; transfer when in_valid && in_ready
//  alu_op     in   2      00 add (ld/st), 01 sub (beq), 10 use funct, 11 reserved
//  funct      in   6      R-type funct field
//  op_a       in   WIDTH  rs operand
//  op_b       in   WIDTH  rt operand
//  out_valid  out  1      one-cycle pulse: result/zero/illegal are valid
//  result     out  WIDTH  registered result
//  zero       out  1      result == 0, registered with result
//  illegal    out  1      op not supported, registered with result
//  hi, lo     out  WIDTH  HI/LO architectural registers
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, out_valid=0, result=0, zero=0, illegal=0, hi=0, lo=0.
//   Reset mid mult/div abandons the op and clears HI/LO.
//  Decode:
//   alu_op 00 -> add; alu_op 01 -> sub; alu_op 11 -> illegal.
//   alu_op 10, funct values:
//    100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor
//    101010 slt (signed), 101011 sltu
//    011000 mult, 011001 multu, 011010 div, 011011 divu
//    010000 mfhi, 010010 mflo
//    any other funct -> illegal.
//  Add/sub wrap modulo 2^WIDTH; no overflow trap. slt/sltu result is 0 or 1, zero-extended.
//  Illegal op: result=0, zero=1, illegal=1, single-cycle latency, HI/LO unchanged.
//  FSM states: IDLE, MUL, DIV. in_ready = (state==IDLE). in_valid is ignored while in_ready=0.
//  Single-cycle ops (incl. mfhi/mflo, illegal): accepted at edge N, out_valid=1 during cycle N+1.
//   Back-to-back accepts every cycle are allowed.
//  mfhi/mflo return HI/LO as of the accept edge.
//  mult/multu:
//   IDLE->MUL; shift-add over |a|,|b| for WIDTH cycles; signed uses magnitudes, product negated if a^b sign.
//   Completes with {hi,lo} = 2*WIDTH-bit product.
//   out_valid pulses at cycle N+WIDTH+1 with result=lo; state->IDLE in that cycle (in_ready=1 there).
//  div/divu:
//   IDLE->DIV; restoring division for WIDTH cycles; same latency and exit rules as MUL.
//   lo=quotient, hi=remainder; signed: quotient sign = a^b, remainder sign = sign of a.
//   Divide by zero: no DIV state, single-cycle; lo = all ones, hi = op_a, illegal=0.
//   Signed MIN / -1: lo=MIN, hi=0.
//  HI/LO update only on the out_valid cycle of mult/div; result/zero/illegal hold between pulses.
// TESTING (WIDTH=32 unless noted)
//  1 alu_op=10 funct=101010 a=FFFFFFFF b=1 -> next cycle out_valid, result=1; sltu same operands -> result=0, zero=1
//  2 alu_op=00 a=FFFFFFFF b=1 then alu_op=01 a=5 b=5 on consecutive cycles -> results 0 (zero=1) and 0, two pulses
//  3 mult a=FFFFFFFE(-2) b=3 -> in_ready low 32 cycles, out_valid at N+33, hi=FFFFFFFF lo=FFFFFFFA; then mfhi -> FFFFFFFF
//  4 div a=FFFFFFF9(-7) b=2 -> lo=FFFFFFFD hi=FFFFFFFF; divu a=7 b=0 -> 1-cycle, lo=FFFFFFFF hi=7
//  5 funct=001111 or alu_op=11 -> illegal=1 result=0; ENABLE_MULDIV=0 with mult -> illegal=1, HI/LO stay 0
//  6 rst_n=0 at cycle 10 of a mult -> next cycle in_ready=1, out_valid never pulses, hi=lo=0

Source files
------------

// File: rtl/alu_ctrl_exec.sv
// alu_ctrl_exec: MIPS EX-stage ALU control decode plus execute.
// Single-cycle ops register their result on the accept edge; mult/div
// iterate one bit per cycle and land in HI/LO, with a valid/ready handshake
// that holds off new requests while the iterative unit is busy.
module alu_ctrl_exec #(
    parameter int WIDTH         = 32,
    parameter int ENABLE_MULDIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
    typedef enum logic [3:0] {
        K_ADD, K_SUB, K_AND, K_OR, K_NOR, K_SLT, K_SLTU,
        K_MULT, K_MULTU, K_DIV, K_DIVU, K_MFHI, K_MFLO, K_ILL
    } kind_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   acc_q, lsr_q, opd_q;
    logic               neg_q, rneg_q;
    logic               out_valid_q, zero_q, illegal_q;
    logic [WIDTH-1:0]   result_q, hi_q, lo_q;

    kind_t              kind;
    logic [WIDTH-1:0]   sc_res, mag_a, mag_b;
    logic               sc_ill, is_signed, sa, sb;
    logic [WIDTH:0]     mul_sum, div_sh, div_tr;
    logic [WIDTH-1:0]   mul_acc_n, mul_lsr_n, div_acc_n, div_lsr_n;
    logic [WIDTH-1:0]   div_q_fin, div_r_fin;
    logic [2*WIDTH-1:0] mul_prod, mul_fin;
    logic               last;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

    // Decode alu_op/funct into an operation kind; mul/div kinds fold to illegal when disabled.
    always_comb begin
        kind = K_ILL;
        unique case (alu_op)
            2'b00: kind = K_ADD;
            2'b01: kind = K_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: kind = K_ADD;
                    6'b100010: kind = K_SUB;
                    6'b100100: kind = K_AND;
                    6'b100101: kind = K_OR;
                    6'b100111: kind = K_NOR;
                    6'b101010: kind = K_SLT;
                    6'b101011: kind = K_SLTU;
                    6'b011000: kind = (ENABLE_MULDIV != 0) ? K_MULT  : K_ILL;
                    6'b011001: kind = (ENABLE_MULDIV != 0) ? K_MULTU : K_ILL;
                    6'b011010: kind = (ENABLE_MULDIV != 0) ? K_DIV   : K_ILL;
                    6'b011011: kind = (ENABLE_MULDIV != 0) ? K_DIVU  : K_ILL;
                    6'b010000: kind = (ENABLE_MULDIV != 0) ? K_MFHI  : K_ILL;
                    6'b010010: kind = (ENABLE_MULDIV != 0) ? K_MFLO  : K_ILL;
                    default:   kind = K_ILL;
                endcase
            end
            default: kind = K_ILL;
        endcase
    end

    // Single-cycle datapath and operand magnitudes for the iterative unit.
    always_comb begin
        sc_res = '0;
        sc_ill = 1'b0;
        case (kind)
            K_ADD:   sc_res = op_a + op_b;
            K_SUB:   sc_res = op_a - op_b;
            K_AND:   sc_res = op_a & op_b;
            K_OR:    sc_res = op_a | op_b;
            K_NOR:   sc_res = ~(op_a | op_b);
            K_SLT:   sc_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            K_SLTU:  sc_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            K_MFHI:  sc_res = hi_q;
            K_MFLO:  sc_res = lo_q;
            K_ILL:   sc_ill = 1'b1;
            default: sc_res = '0;
        endcase
        is_signed = (kind == K_MULT) || (kind == K_DIV);
        sa        = is_signed & op_a[WIDTH-1];
        sb        = is_signed & op_b[WIDTH-1];
        mag_a     = sa ? (-op_a) : op_a;
        mag_b     = sb ? (-op_b) : op_b;
    end

    // One shift-add / restoring-divide step, plus sign fix-up for the final step.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (lsr_q[0] ? {1'b0, opd_q} : '0);
        mul_acc_n = mul_sum[WIDTH:1];
        mul_lsr_n = {mul_sum[0], lsr_q[WIDTH-1:1]};
        mul_prod  = {mul_acc_n, mul_lsr_n};
        mul_fin   = neg_q ? (-mul_prod) : mul_prod;
        div_sh    = {acc_q, lsr_q[WIDTH-1]};
        div_tr    = div_sh - {1'b0, opd_q};
        div_acc_n = div_tr[WIDTH] ? div_sh[WIDTH-1:0] : div_tr[WIDTH-1:0];
        div_lsr_n = {lsr_q[WIDTH-2:0], ~div_tr[WIDTH]};
        div_q_fin = neg_q  ? (-div_lsr_n) : div_lsr_n;
        div_r_fin = rneg_q ? (-div_acc_n) : div_acc_n;
        last      = (cnt_q == CW'(WIDTH-1));
    end

    // Control FSM with registered outputs and HI/LO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            lsr_q       <= '0;
            opd_q       <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        case (kind)
                            K_MULT, K_MULTU: begin
                                state_q <= S_MUL;
                                cnt_q   <= '0;
                                acc_q   <= '0;
                                lsr_q   <= mag_b;
                                opd_q   <= mag_a;
                                neg_q   <= sa ^ sb;
                                rneg_q  <= 1'b0;
                            end
                            K_DIV, K_DIVU: begin
                                if (op_b == '0) begin
                                    out_valid_q <= 1'b1;
                                    result_q    <= '1;
                                    zero_q      <= 1'b0;
                                    illegal_q   <= 1'b0;
                                    lo_q        <= '1;
                                    hi_q        <= op_a;
                                end else begin
                                    state_q <= S_DIV;
                                    cnt_q   <= '0;
                                    acc_q   <= '0;
                                    lsr_q   <= mag_a;
                                    opd_q   <= mag_b;
                                    neg_q   <= sa ^ sb;
                                    rneg_q  <= sa;
                                end
                            end
                            default: begin
                                out_valid_q <= 1'b1;
                                result_q    <= sc_res;
                                zero_q      <= (sc_res == '0);
                                illegal_q   <= sc_ill;
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    cnt_q <= cnt_q + 1'b1;
                    acc_q <= mul_acc_n;
                    lsr_q <= mul_lsr_n;
                    if (last) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b1;
                        hi_q        <= mul_fin[2*WIDTH-1:WIDTH];
                        lo_q        <= mul_fin[WIDTH-1:0];
                        result_q    <= mul_fin[WIDTH-1:0];
                        zero_q      <= (mul_fin[WIDTH-1:0] == '0);
                        illegal_q   <= 1'b0;
                    end
                end
                S_DIV: begin
                    cnt_q <= cnt_q + 1'b1;
                    acc_q <= div_acc_n;
                    lsr_q <= div_lsr_n;
                    if (last) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b1;
                        hi_q        <= div_r_fin;
                        lo_q        <= div_q_fin;
                        result_q    <= div_q_fin;
                        zero_q      <= (div_q_fin == '0);
                        illegal_q   <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Scoreboard bench for alu_ctrl_exec (WIDTH=32) plus a mul/div-disabled instance.
module tb_alu_ctrl_exec;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ill;
        logic [31:0] hi;
        logic [31:0] lo;
        int          edge_n;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   ecount = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  alu_op = '0;
    logic [5:0]  funct = '0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        out_valid, zero, illegal;
    logic [31:0] result, hi, lo;

    logic        in_valid0 = 1'b0;
    logic        in_ready0;
    logic        out_valid0, zero0, illegal0;
    logic [31:0] result0, hi0, lo0;

    alu_ctrl_exec #(.WIDTH(32), .ENABLE_MULDIV(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .result(result), .zero(zero), .illegal(illegal),
        .hi(hi), .lo(lo)
    );

    alu_ctrl_exec #(.WIDTH(32), .ENABLE_MULDIV(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .alu_op(alu_op), .funct(funct), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid0), .result(result0), .zero(zero0), .illegal(illegal0),
        .hi(hi0), .lo(lo0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecount++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, expv);
        end
    endtask

    // Monitor: pop and compare on every output pulse.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("result",  result,  e.res);
                chk("zero",    {31'd0, zero},    {31'd0, e.z});
                chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
                chk("hi",      hi,      e.hi);
                chk("lo",      lo,      e.lo);
                chk("latency_edge", ecount, e.edge_n);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic z, input logic ill,
                        input logic [31:0] h, input logic [31:0] l,
                        input int lat, input bit push);
        exp_t e;
        wait_ready();
        alu_op = op; funct = f; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) begin
            e.res = res; e.z = z; e.ill = ill; e.hi = h; e.lo = l;
            e.edge_n = ecount + lat;
            sbq.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {30'd0, zero, illegal}, 32'd0);
        chk("rst_hilo", hi | lo, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // slt / sltu on identical operands
        send(2'b10, 6'b101010, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1);
        send(2'b10, 6'b101011, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 0, 1);
        // back-to-back add (wrap) and sub
        send(2'b00, 6'b000000, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 0, 1);
        send(2'b01, 6'b000000, 32'h5,        32'h5, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 0, 1);
        // logic and R-type arithmetic
        send(2'b10, 6'b100100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1);
        send(2'b10, 6'b100101, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1);
        send(2'b10, 6'b100111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1);
        send(2'b10, 6'b100010, 32'h3,        32'h5,        32'hFFFFFFFE, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1);
        send(2'b10, 6'b100000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1);

        // signed mult -2 * 3, with busy-window check
        send(2'b10, 6'b011000, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFA, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, 32, 1);
        n = 0;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        chk("mult_busy_cycles", n, 32);
        send(2'b10, 6'b010000, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 1);
        send(2'b10, 6'b010010, 32'h0, 32'h0, 32'hFFFFFFFA, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 1);

        // illegal ops leave HI/LO alone
        send(2'b10, 6'b001111, 32'h12, 32'h34, 32'h0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 1);
        send(2'b11, 6'b100000, 32'h12, 32'h34, 32'h0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 1);

        // multu max*max, mult by zero
        send(2'b10, 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h1, 32, 1);
        send(2'b10, 6'b011000, 32'h0, 32'h5, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32, 1);

        // division cases
        send(2'b10, 6'b011010, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 32, 1);
        send(2'b10, 6'b011010, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0, 32'h1,        32'hFFFFFFFD, 32, 1);
        send(2'b10, 6'b011011, 32'h7,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 32'h7,        32'hFFFFFFFF, 0, 1);
        send(2'b10, 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 32'h0,        32'h80000000, 32, 1);
        send(2'b10, 6'b011011, 32'd100,      32'd7,        32'hE,        1'b0, 1'b0, 32'h2,        32'hE, 32, 1);
        send(2'b10, 6'b011010, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFF9, 32'hFFFFFFFF, 0, 1);
        wait_ready();
        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained_pre_reset", sbq.size(), 0);

        // reset at cycle 10 of a mult abandons it
        send(2'b10, 6'b011001, 32'h3, 32'h5, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_hi", hi, 32'h0);
        chk("rst_mid_lo", lo, 32'h0);
        repeat (40) @(posedge clk);
        #1;

        // mul/div disabled: mult decodes as illegal
        alu_op = 2'b10; funct = 6'b011000; op_a = 32'h6; op_b = 32'h7; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        chk("nomd_out_valid", {31'd0, out_valid0}, 32'd1);
        chk("nomd_illegal", {31'd0, illegal0}, 32'd1);
        chk("nomd_result", result0, 32'h0);
        chk("nomd_hilo", hi0 | lo0, 32'h0);
        chk("nomd_in_ready", {31'd0, in_ready0}, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
